// File: rtl/store_drain_buffer.sv
//------------------------------------------------------------------------------
// Module      : store_drain_buffer
// Description : In-order CPU store buffer draining into the data memory write
//               port over a valid/ack handshake, with store-to-load forwarding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_drain_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr_mem [DEPTH];
    logic [DATA_W-1:0]   r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_push;
    logic                w_pop;
    logic [c_CNT_W-1:0]  w_count_next;
    logic [c_PTR_W-1:0]  w_sel_ptr;
    logic [c_CNT_W-1:0]  w_sel_stored;
    logic [ADDR_W-1:0]   w_load_addr;
    logic [DATA_W-1:0]   w_load_data;
    logic                w_fwd_hit;
    logic [DATA_W-1:0]   w_fwd_data;
    logic [c_PTR_W-1:0]  w_idx;

    assign wr_ready = (r_count != c_CNT_W'(DEPTH));
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = r_mem_we && mem_ack;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Entry that will be head next cycle: from storage if one is already
    // stored beyond the popped head, otherwise the store arriving right now.
    assign w_sel_ptr    = w_pop ? (r_head + c_PTR_W'(1)) : r_head;
    assign w_sel_stored = r_count - c_CNT_W'(w_pop);
    assign w_load_addr  = (w_sel_stored != '0) ? r_addr_mem[w_sel_ptr] : wr_addr;
    assign w_load_data  = (w_sel_stored != '0) ? r_data_mem[w_sel_ptr] : wr_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= wr_addr;
            r_data_mem[r_tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_pop);
            r_tail  <= r_tail + c_PTR_W'(w_push);
            r_count <= w_count_next;
            case (r_state)
                S_IDLE: begin
                    if (w_count_next != '0) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_load_addr;
                        r_mem_wdata <= w_load_data;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_pop) begin
                        if (w_count_next != '0) begin
                            r_mem_addr  <= w_load_addr;
                            r_mem_wdata <= w_load_data;
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Walk entries oldest to youngest so the last match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) && (r_addr_mem[w_idx] == rd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data_mem[w_idx];
            end
        end
    end

    assign fwd_hit   = w_fwd_hit;
    assign fwd_data  = w_fwd_data;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_store_drain_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_store_drain_buffer
// Description : Directed self-checking bench for store_drain_buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_drain_buffer;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] rd_addr;
    logic       fwd_hit;
    logic [7:0] fwd_data;
    logic [2:0] count;
    logic       empty;

    int errors = 0;
    int checks = 0;

    store_drain_buffer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        mem_ack = 1'b0; rd_addr = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus got=%h/%h exp=00/00", mem_addr, mem_wdata); end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin errors++; $display("FAIL reset_fwd got=%b/%h exp=0/00", fwd_hit, fwd_data); end
        // Ack while idle must not pop anything.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (count !== 3'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_ack got=%0d/%b exp=0/0", count, mem_we); end
    endtask

    task automatic test_single();
        mem_ack = 1'b1;
        wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        rd_addr = 8'd3;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd3 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL single_present got=%b/%h/%h exp=1/03/a5", mem_we, mem_addr, mem_wdata); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'hA5) begin errors++; $display("FAIL single_fwd_popping got=%b/%h exp=1/a5", fwd_hit, fwd_data); end
        tick();
        checks++; if (mem_we !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_done got=%b/%0d/%b exp=0/0/1", mem_we, count, empty); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL single_fwd_gone got=%b exp=0", fwd_hit); end
        mem_ack = 1'b0;
    endtask

    task automatic test_fill_stall();
        logic [7:0] d;
        mem_ack = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1'b1; wr_addr = 8'(i); wr_data = 8'(i * 8'h11);
            #1;
            checks++; if (wr_ready !== (i <= 4)) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, wr_ready, (i <= 4)); end
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (count !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%0d/%b exp=4/0", count, wr_ready); end
        tick(); tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wdata !== 8'h11) begin errors++; $display("FAIL fill_hold got=%b/%h/%h exp=1/01/11", mem_we, mem_addr, mem_wdata); end
        rd_addr = 8'd5;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fill_ignored_fwd got=%b exp=0", fwd_hit); end
        rd_addr = 8'd3;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h33) begin errors++; $display("FAIL fill_fwd3 got=%b/%h exp=1/33", fwd_hit, fwd_data); end
        mem_ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            d = 8'(k * 8'h11);
            checks++; if (mem_we !== 1'b1 || mem_addr !== 8'(k) || mem_wdata !== d) begin errors++; $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", k, mem_we, mem_addr, mem_wdata, 8'(k), d); end
            tick();
        end
        checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_done got=%b/%0d exp=0/0", mem_we, count); end
        mem_ack = 1'b0;
    endtask

    task automatic test_forward();
        mem_ack = 1'b0;
        wr_valid = 1'b1; wr_addr = 8'd7; wr_data = 8'h01;
        tick();
        wr_addr = 8'd7; wr_data = 8'h02;
        rd_addr = 8'd7;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h01) begin errors++; $display("FAIL fwd_same_cycle got=%b/%h exp=1/01", fwd_hit, fwd_data); end
        tick();
        wr_valid = 1'b0;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h02) begin errors++; $display("FAIL fwd_youngest got=%b/%h exp=1/02", fwd_hit, fwd_data); end
        rd_addr = 8'd8;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/00", fwd_hit, fwd_data); end
        rd_addr = 8'd7;
        mem_ack = 1'b1;
        tick();
        checks++; if (count !== 3'd1 || mem_addr !== 8'd7 || mem_wdata !== 8'h02 || fwd_data !== 8'h02) begin errors++; $display("FAIL fwd_after_pop got=%0d/%h/%h/%h exp=1/07/02/02", count, mem_addr, mem_wdata, fwd_data); end
        tick();
        checks++; if (count !== 3'd0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got=%0d/%b exp=0/0", count, fwd_hit); end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_ack = 1'b1;
        wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 8'h80;
        tick();
        for (int i = 1; i <= 10; i++) begin
            checks++; if (mem_we !== 1'b1 || mem_addr !== 8'(8'h20 + i - 1) || mem_wdata !== 8'(8'h80 + i - 1)) begin errors++; $display("FAIL b2b_write_%0d got=%b/%h/%h exp=1/%h/%h", i, mem_we, mem_addr, mem_wdata, 8'(8'h20 + i - 1), 8'(8'h80 + i - 1)); end
            wr_addr = 8'(8'h20 + i); wr_data = 8'(8'h80 + i);
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count_%0d got=%0d exp=1", i, count); end
        end
        wr_valid = 1'b0;
        checks++; if (mem_addr !== 8'h2A || mem_wdata !== 8'h8A) begin errors++; $display("FAIL b2b_last got=%h/%h exp=2a/8a", mem_addr, mem_wdata); end
        tick();
        checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL b2b_done got=%b/%0d exp=0/0", mem_we, count); end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 8'(8'h40 + i); wr_data = 8'(i + 1);
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (count !== 3'd3 || mem_we !== 1'b1) begin errors++; $display("FAIL mid_pending got=%0d/%b exp=3/1", count, mem_we); end
        rst = 1'b1; mem_ack = 1'b1;
        wr_valid = 1'b1; wr_addr = 8'h43; wr_data = 8'h04;
        tick();
        rst = 1'b0; mem_ack = 1'b0; wr_valid = 1'b0;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin errors++; $display("FAIL mid_reset got=%0d/%b/%b/%h exp=0/1/0/00", count, empty, mem_we, mem_addr); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 8'(8'h40 + i);
            #1;
            checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL mid_fwd_%h got=%b exp=0", rd_addr, fwd_hit); end
        end
        tick();
        checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_settled got=%b/%0d exp=0/0", mem_we, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_forward();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Write-side companion to the data memory read path: buffers CPU store requests (address/data pairs) and drains them in order into the memory array's write port.
- Uses a valid/ack handshake on the memory side.
- Supplies store-to-load forwarding so a read of an address with a pending store returns the buffered data.
- Sits between the CPU MEM stage and the data memory.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
DEPTH, 4, number of buffer entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wr_valid  input  1  CPU presents a store this cycle
wr_ready  output  1  buffer can accept a store (= !full)
wr_addr  input  ADDR_W  store address
wr_data  input  DATA_W  store data
mem_we  output  1  registered; head entry is being presented to memory
mem_addr  output  ADDR_W  registered; head entry address
mem_wdata  output  DATA_W  registered; head entry data
mem_ack  input  1  memory has written mem_wdata at mem_addr this cycle
rd_addr  input  ADDR_W  load address for forwarding lookup
fwd_hit  output  1  a pending entry matches rd_addr
fwd_data  output  DATA_W  data of youngest matching entry, 0 when no hit
count  output  $clog2(DEPTH)+1  occupied entries
empty  output  1  count == 0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - count = 0, empty = 1, wr_ready = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Head and tail pointers = 0, FSM = IDLE.
  - Entry contents are don't-care but must never be forwarded while empty.
- Reset mid-drain: pending entries are discarded; mem_we drops the cycle after rst is sampled. Reset dominates push and ack in the same cycle.
- Storage: circular array of DEPTH entries; head and tail pointers each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
- Push: on wr_valid && wr_ready, write {wr_addr, wr_data} at tail, tail+1.
  - wr_valid while full is ignored: no state change, no error flag.
  - wr_ready is combinational from count only; it does not look ahead to a same-cycle pop.
- Pop: on mem_we && mem_ack, head+1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Drain FSM:
  - IDLE: mem_we = 0.
    - If count becomes non-zero, load mem_addr/mem_wdata from the entry that will be head next cycle and set mem_we.
    - Go to REQ.
    - A store pushed in cycle N is presented with mem_we = 1 in cycle N+1 (1-cycle latency).
  - REQ: mem_we = 1; mem_addr and mem_wdata are held stable until mem_ack.
    - On ack with entries remaining after the pop: load the next head, stay in REQ. Back-to-back writes are possible with no bubble.
    - On ack with none remaining (including a push arriving the same cycle is counted as remaining): mem_we = 0, go to IDLE.
  - mem_ack outside REQ is ignored.
- Ordering: memory writes occur strictly in push order; stores to the same address are never merged.
- Forwarding (combinational):
  - Compare rd_addr against all occupied entries, including the head currently being written.
  - fwd_hit = 1 if any entry matches; fwd_data = data of the youngest match (closest to tail).
  - A store pushed this cycle is not visible until the next cycle.
  - An entry popped this cycle is still visible this cycle and gone the next.
- Widths: count arithmetic is unsigned. Address comparison is exact over the full ADDR_W bits.

Test Plan:
- Reset then idle: assert rst 2 cycles -> count = 0, empty = 1, wr_ready = 1, mem_we = 0, fwd_hit = 0 for rd_addr = 0.
- Single store, immediate ack: push (addr 3, data 0xA5) in cycle N; mem_ack = 1 constantly -> mem_we = 1, mem_addr = 3, mem_wdata = 0xA5 in N+1; count back to 0 and mem_we = 0 in N+2.
- Fill and stall: mem_ack = 0, push 5 stores (1:0x11, 2:0x22, 3:0x33, 4:0x44, 5:0x55).
  - wr_ready = 0 after 4 pushes, the 5th is ignored, count = 4.
  - mem_addr held at 1 until ack.
  - Then ack every cycle -> writes 1, 2, 3, 4 in consecutive cycles, no bubble.
- Forwarding youngest: with ack held low, push (7:0x01), then (7:0x02).
  - rd_addr = 7 -> fwd_hit = 1, fwd_data = 0x02.
  - rd_addr = 8 -> fwd_hit = 0, fwd_data = 0.
- Simultaneous push/pop with wrap: keep count at 1 while pushing and acking every cycle for 10 cycles -> count stays 1, pointers wrap, memory writes appear in push order with correct data.
- Reset mid-drain: 3 entries pending, mem_we = 1; assert rst together with mem_ack -> next cycle count = 0, mem_we = 0, fwd_hit = 0 for all pending addresses.
